// File: rtl/truth_table_capture.sv
// Sequential truth-table reader for 3-input, 1-output logic blocks: walks rows 000..111,
// majority-votes the sensed output per row and reports the 8-bit code plus a match flag.
module truth_table_capture #(
    parameter int SETTLE_CYCLES = 4,
    parameter int SAMPLES       = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] expected,
    input  logic       sense,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       busy,
    output logic       done,
    output logic [7:0] code,
    output logic       match
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0] SAMPLE_LAST = 4'(SAMPLES - 1);
    localparam logic [5:0] SAMPLES_W   = 6'(SAMPLES);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t     state;
    logic [2:0] row;
    logic [7:0] settle_cnt;
    logic [3:0] sample_cnt;
    logic [3:0] ones_count;
    logic [7:0] shadow;

    logic [4:0] ones_total;
    logic       row_bit;
    logic [7:0] shadow_next;

    // Vote includes the sample taken on the current edge; row 000 lands in the MSB.
    always_comb begin
        ones_total  = {1'b0, ones_count} + {4'b0000, sense};
        row_bit     = ({ones_total, 1'b0} > SAMPLES_W);
        shadow_next = shadow;
        shadow_next[3'd7 - row] = row_bit;
    end

    assign {in1, in2, in3} = row;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            row        <= 3'd0;
            settle_cnt <= 8'd0;
            sample_cnt <= 4'd0;
            ones_count <= 4'd0;
            shadow     <= 8'h00;
            busy       <= 1'b0;
            done       <= 1'b0;
            code       <= 8'h00;
            match      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy       <= 1'b1;
                        row        <= 3'd0;
                        settle_cnt <= 8'd0;
                        sample_cnt <= 4'd0;
                        ones_count <= 4'd0;
                        shadow     <= 8'h00;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= 8'd0;
                        sample_cnt <= 4'd0;
                        ones_count <= 4'd0;
                        state      <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end
                SAMPLE: begin
                    if (sample_cnt == SAMPLE_LAST) begin
                        shadow     <= shadow_next;
                        sample_cnt <= 4'd0;
                        ones_count <= 4'd0;
                        if (row == 3'd7) begin
                            code  <= shadow_next;
                            match <= (shadow_next == expected);
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            row        <= row + 3'd1;
                            settle_cnt <= 8'd0;
                            state      <= SETTLE;
                        end
                    end else begin
                        ones_count <= ones_total[3:0];
                        sample_cnt <= sample_cnt + 4'd1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    row   <= 3'd0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_capture.sv
// Bench for truth_table_capture: a cycle-level reference model is compared with the
// default instance every cycle, and a fast-parameter instance gets directed checks.
module tb_truth_table_capture;

    localparam int S      = 4;
    localparam int N      = 3;
    localparam int ROWLEN = S + N;
    localparam int LAT    = 1 + 8 * ROWLEN;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] expected;
    logic       sense;
    logic       in1, in2, in3, busy, done, match;
    logic [7:0] code;

    logic       start_f;
    logic [7:0] expected_f;
    logic       sense_f;
    logic       in1_f, in2_f, in3_f, busy_f, done_f, match_f;
    logic [7:0] code_f;

    logic [7:0] gate_code = 8'h00;
    logic [7:0] fgate = 8'h96;
    int         inv_k = 0;
    logic       inv_now = 1'b0;
    bit         chk_en = 1'b0;

    int total = 0;
    int bad   = 0;

    bit         m_active = 1'b0;
    int         m_k = 0;
    logic [7:0] m_code = 8'h00;
    logic       m_match = 1'b0;

    always #5 clk = ~clk;

    assign sense   = gate_code[3'd7 - {in1, in2, in3}] ^ inv_now;
    assign sense_f = fgate[3'd7 - {in1_f, in2_f, in3_f}];

    truth_table_capture dut (
        .clk(clk), .reset(reset), .start(start), .expected(expected), .sense(sense),
        .in1(in1), .in2(in2), .in3(in3), .busy(busy), .done(done), .code(code), .match(match)
    );

    truth_table_capture #(.SETTLE_CYCLES(1), .SAMPLES(1)) dut_fast (
        .clk(clk), .reset(reset), .start(start_f), .expected(expected_f), .sense(sense_f),
        .in1(in1_f), .in2(in2_f), .in3(in3_f), .busy(busy_f), .done(done_f), .code(code_f),
        .match(match_f)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] wanted);
        total++;
        if (actual !== wanted) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, wanted);
        end
    endtask

    // Reference: m_k counts cycles since the accepting edge; the captured code follows
    // from the gate and how many of the N votes per row were forced wrong.
    always @(posedge clk) begin
        if (reset) begin
            m_active = 1'b0;
            m_k      = 0;
            m_code   = 8'h00;
            m_match  = 1'b0;
        end else if (m_active) begin
            if (m_k == LAT) begin
                m_active = 1'b0;
                m_k      = 0;
            end else begin
                m_k++;
                if (m_k == LAT) begin
                    m_code  = gate_code ^ ((2 * inv_k > N) ? 8'hFF : 8'h00);
                    m_match = (m_code == expected);
                end
            end
        end else if (start) begin
            m_active = 1'b1;
            m_k      = 1;
        end
    end

    always @(negedge clk) begin
        int pos;
        pos     = (m_k - 1) % ROWLEN;
        inv_now = m_active && (m_k < LAT) && (pos >= S) && (pos < S + inv_k);
    end

    always @(negedge clk) begin
        int exp_row;
        if (chk_en) begin
            if (!m_active)      exp_row = 0;
            else if (m_k == LAT) exp_row = 7;
            else                exp_row = (m_k - 1) / ROWLEN;
            checkOutput("busy",  32'(busy),  32'(m_active));
            checkOutput("done",  32'(done),  32'(m_active && m_k == LAT));
            checkOutput("row",   32'({in1, in2, in3}), 32'(exp_row));
            checkOutput("code",  32'(code),  32'(m_code));
            checkOutput("match", 32'(match), 32'(m_match));
        end
    end

    task automatic applyStimulus(input logic [7:0] gate, input logic [7:0] exp_in, input int inv);
        gate_code = gate;
        expected  = exp_in;
        inv_k     = inv;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic runCapture(input logic [7:0] gate, input logic [7:0] exp_in, input int inv,
                              input logic [7:0] want_code, input logic want_match);
        int cycles;
        applyStimulus(gate, exp_in, inv);
        cycles = 1;
        while (!done && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("latency", 32'(cycles), 32'(57));
        checkOutput("code_lit", 32'(code), 32'(want_code));
        checkOutput("match_lit", 32'(match), 32'(want_match));
        @(negedge clk);
    endtask

    initial begin
        int first, second, ndone, cycles;
        reset      = 1'b1;
        start      = 1'b0;
        expected   = 8'h00;
        start_f    = 1'b0;
        expected_f = 8'h96;
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;
        checkOutput("reset_code", 32'(code), 32'(8'h00));
        checkOutput("reset_busy", 32'(busy), 32'(0));

        $display("[TB] basic captures");
        runCapture(8'h2B, 8'h2B, 0, 8'h2B, 1'b1);
        runCapture(8'h00, 8'hFF, 0, 8'h00, 1'b0);
        runCapture(8'hFF, 8'hFF, 0, 8'hFF, 1'b1);

        $display("[TB] majority vote");
        runCapture(8'h2B, 8'h2B, 1, 8'h2B, 1'b1);
        runCapture(8'h2B, 8'h2B, 2, 8'hD4, 1'b0);

        $display("[TB] start while busy");
        gate_code = 8'h2B; expected = 8'h2B; inv_k = 0;
        @(negedge clk);
        start = 1'b1;
        first = 0; ndone = 0;
        for (int c = 1; c <= 130; c++) begin
            @(negedge clk);
            start = (c == 5 || c == 30 || c == 57);
            if (done) begin
                ndone++;
                if (first == 0) first = c;
            end
        end
        start = 1'b0;
        checkOutput("ignore_first", 32'(first), 32'(57));
        checkOutput("ignore_count", 32'(ndone), 32'(1));

        $display("[TB] held start");
        @(negedge clk);
        start = 1'b1;
        first = 0; second = 0; ndone = 0;
        for (int c = 1; c <= 130; c++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (first == 0) first = c;
                else if (second == 0) second = c;
            end
            if (c == 60) start = 1'b0;
        end
        checkOutput("held_first", 32'(first), 32'(57));
        checkOutput("held_second", 32'(second), 32'(115));
        checkOutput("held_count", 32'(ndone), 32'(2));

        $display("[TB] reset mid-capture");
        gate_code = 8'h00; expected = 8'h00;
        @(negedge clk);
        start = 1'b1;
        ndone = 0;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 20) reset = 1'b1;
            if (c == 21) begin
                reset = 1'b0;
                checkOutput("abort_row", 32'({in1, in2, in3}), 32'(0));
                checkOutput("abort_busy", 32'(busy), 32'(0));
                checkOutput("abort_code", 32'(code), 32'(8'h00));
            end
            if (done) ndone++;
        end
        checkOutput("abort_nodone", 32'(ndone), 32'(0));
        runCapture(8'h2B, 8'h2B, 0, 8'h2B, 1'b1);

        $display("[TB] fast parameters");
        @(negedge clk);
        start_f = 1'b1;
        @(negedge clk);
        start_f = 1'b0;
        cycles = 1;
        while (!done_f && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("fast_latency", 32'(cycles), 32'(17));
        checkOutput("fast_code", 32'(code_f), 32'(8'h96));
        checkOutput("fast_match", 32'(match_f), 32'(1));
        @(negedge clk);
        checkOutput("fast_idle", 32'(busy_f), 32'(0));

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
